// File: rtl/mac_pkg.sv
// Shared encodings for the MAC command interface: command codes, sequencer
// state encodings and a counter-width helper.
package mac_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_MAC = 2'b01;
  localparam logic [1:0] CMD_CLR = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef logic [1:0] cmd_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mac_cmd_sequencer_if.sv
// Job/operand/command bundle between the sequencer (master) and the
// job requester, operand source and MAC control FSM (slave).
interface mac_cmd_sequencer_if #(parameter int LEN_W = 8);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       cmd;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, len, op_valid,
    output op_ready, cmd, busy, done, err
  );

  modport slave (
    output start, len, op_valid,
    input  op_ready, cmd, busy, done, err
  );

endinterface

// File: rtl/mac_seq_counter.sv
// Up-counter with synchronous clear, enable and an equality terminal-compare
// flag; used for both the element counter and the stall counter.
module mac_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/mac_cmd_sequencer.sv
// Dot-product command sequencer: CLR, one MAC per operand transfer, RD, DONE.
// Define MAC_SEQ_STALL_TIMEOUT_EN to abort a job after TIMEOUT stall cycles.
//
//   state | meaning
//   IDLE  | waiting for START, latches LEN
//   CLEAR | one cycle of CMD=CLR
//   RUN   | OP_READY high, CMD=MAC on each transfer
//   FLUSH | one cycle of CMD=RD
//   FIN   | one-cycle DONE pulse (with ERR on stall abort)
module mac_cmd_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_cmd_sequencer_if.master  bus
);

  if (TIMEOUT < 1 || LEN_W < 1) begin : g_param_check
    $error("mac_cmd_sequencer: TIMEOUT and LEN_W must be at least 1");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [LEN_W-1:0] len_q;
  logic             xfer;
  logic             cnt_tc;
  logic             last;
  logic             stall_hit;
  cmd_t             cmd;

  assign xfer = (state == ST_RUN) && bus.op_valid;
  // Compare against len_q-1 so the final transfer is seen before count wraps.
  assign last = xfer && cnt_tc;

  mac_seq_counter #(.W(LEN_W)) u_elem_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .en     (xfer),
    .tc_val (len_q - LEN_W'(1)),
    .tc     (cnt_tc)
  );

`ifdef MAC_SEQ_STALL_TIMEOUT_EN
  localparam int SW = cnt_width(TIMEOUT);

  logic stall_en;
  logic stall_tc;
  logic err_q;

  assign stall_en  = (state == ST_RUN) && !bus.op_valid;
  assign stall_hit = stall_en && stall_tc;

  mac_seq_counter #(.W(SW)) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!stall_en),
    .en     (stall_en),
    .tc_val (SW'(TIMEOUT - 1)),
    .tc     (stall_tc)
  );

  // Abort edge leads straight into FIN, so this flag lines up with that cycle.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= stall_hit;
  end

  assign bus.err = err_q;
`else
  assign stall_hit = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (len_q != '0) ? ST_RUN : ST_FLUSH;
      ST_RUN: begin
        if (last)           state_nxt = ST_FLUSH;
        else if (stall_hit) state_nxt = ST_FIN;
      end
      ST_FLUSH: state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.start) len_q <= bus.len;
    end
  end

  always_comb begin
    cmd = CMD_NOP;
    unique case (state)
      ST_CLEAR: cmd = CMD_CLR;
      ST_RUN:   cmd = bus.op_valid ? CMD_MAC : CMD_NOP;
      ST_FLUSH: cmd = CMD_RD;
      default:  cmd = CMD_NOP;
    endcase
  end

  assign bus.cmd      = cmd;
  assign bus.op_ready = (state == ST_RUN);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_FIN);

endmodule

// File: tb/tb_mac_cmd_sequencer.sv
// Scoreboard bench for mac_cmd_sequencer: stimulus queues expected command
// events with their cycle stamps, a negedge monitor pops and compares them.
module tb_mac_cmd_sequencer;
  import mac_pkg::*;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_cmd_sequencer_if #(.LEN_W(LEN_W)) bus ();

  mac_cmd_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] cmd;
    logic       done;
    logic       err;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc       = 0;
  int  errors    = 0;
  int  checks    = 0;
  int  done_seen = 0;
  int  done_exp  = 0;
  int  mac_seen  = 0;
  int  ready_hi  = 0;
  bit  mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  function automatic void push(input logic [1:0] c, input logic d, input logic e, input int t);
    ev_t ev;
    ev.cmd  = c;
    ev.done = d;
    ev.err  = e;
    ev.cyc  = t;
    exp_q.push_back(ev);
    if (d) done_exp++;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.op_ready) ready_hi++;
      if (bus.cmd == CMD_MAC) mac_seen++;
      if (bus.cmd != CMD_NOP || bus.done) begin
        if (bus.done) done_seen++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_event",
              $sformatf("got cmd=%b done=%b at cyc %0d, required nothing", bus.cmd, bus.done, cyc));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk(bus.cmd == e.cmd && bus.done == e.done && bus.err == e.err && bus.busy == 1'b1 && cyc == e.cyc,
              "event",
              $sformatf("got cmd=%b done=%b err=%b busy=%b cyc=%0d, required cmd=%b done=%b err=%b busy=1 cyc=%0d",
                        bus.cmd, bus.done, bus.err, bus.busy, cyc, e.cmd, e.done, e.err, e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job; pat[i] is OP_VALID in the i-th RUN cycle (1 beyond npat).
  task automatic run_job(input int len, input logic [7:0] pat, input int npat, input int pulse_idx);
    int c0;
    int n;
    int i;
    c0 = cyc;
    bus.start = 1'b1;
    bus.len   = LEN_W'(len);
    push(CMD_CLR, 1'b0, 1'b0, c0 + 1);
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    tick();
    n = 0;
    i = 0;
    while (n < len) begin
      bus.op_valid = (i < npat) ? pat[i] : 1'b1;
      bus.start    = (i == pulse_idx);
      bus.len      = (i == pulse_idx) ? LEN_W'(9) : '0;
      if (bus.op_valid) begin
        push(CMD_MAC, 1'b0, 1'b0, cyc);
        n++;
      end
      tick();
      i++;
    end
    bus.op_valid = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    push(CMD_RD,  1'b0, 1'b0, cyc);
    push(CMD_NOP, 1'b1, 1'b0, cyc + 1);
    tick();
    tick();
  endtask

  initial begin
    int c0;
    int r0;
    int m0;
    int bad;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.op_valid = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk(bus.cmd == CMD_NOP && !bus.busy && !bus.op_ready && !bus.done && !bus.err, "reset_state",
        $sformatf("cmd=%b busy=%b op_ready=%b done=%b err=%b, required all 0",
                  bus.cmd, bus.busy, bus.op_ready, bus.done, bus.err));
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // zero-stall LEN=4: CLR, 4x MAC, RD, DONE on the 7th cycle
    run_job(4, 8'h00, 0, -1);
    tick();

    // stalled LEN=3 with OP_VALID 1,0,0,1,1 and a START pulse mid-RUN
    run_job(3, 8'b0001_1001, 5, 1);

    // LEN=0: CLR, RD, DONE, OP_READY never high
    r0 = ready_hi;
    run_job(0, 8'h00, 0, -1);
    chk(ready_hi == r0, "len0_op_ready", $sformatf("op_ready high %0d cycles, required 0", ready_hi - r0));

    // single pair
    run_job(1, 8'h00, 0, -1);

    // maximum length
    m0 = mac_seen;
    run_job(255, 8'h00, 0, -1);
    chk(mac_seen - m0 == 255, "len255_macs", $sformatf("got %0d MAC commands, required 255", mac_seen - m0));

    // back-to-back with START held high, LEN=2
    c0 = cyc;
    bus.start    = 1'b1;
    bus.len      = LEN_W'(2);
    bus.op_valid = 1'b1;
    push(CMD_CLR, 1'b0, 1'b0, c0 + 1);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 2);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 3);
    push(CMD_RD,  1'b0, 1'b0, c0 + 4);
    push(CMD_NOP, 1'b1, 1'b0, c0 + 5);
    push(CMD_CLR, 1'b0, 1'b0, c0 + 7);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 8);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 9);
    push(CMD_RD,  1'b0, 1'b0, c0 + 10);
    push(CMD_NOP, 1'b1, 1'b0, c0 + 11);
    repeat (6) tick();
    @(negedge clk);
    chk(!bus.busy && bus.cmd == CMD_NOP, "b2b_idle_gap",
        $sformatf("busy=%b cmd=%b in gap cycle, required busy=0 cmd=00", bus.busy, bus.cmd));
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.op_valid = 1'b0;
    tick();

    // reset for 2 cycles in RUN
    c0 = cyc;
    bus.start    = 1'b1;
    bus.len      = LEN_W'(4);
    bus.op_valid = 1'b1;
    push(CMD_CLR, 1'b0, 1'b0, c0 + 1);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 2);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 3);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk(bus.cmd == CMD_NOP && !bus.busy && !bus.op_ready && !bus.done, "reset_in_run",
        $sformatf("cmd=%b busy=%b op_ready=%b done=%b, required all 0",
                  bus.cmd, bus.busy, bus.op_ready, bus.done));
    tick();
    rst          = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    chk(exp_q.size() == 0, "reset_drain", $sformatf("%0d events still pending, required 0", exp_q.size()));

    // LEN=5, stall after 2 transfers
    c0 = cyc;
    bus.start    = 1'b1;
    bus.len      = LEN_W'(5);
    bus.op_valid = 1'b1;
    push(CMD_CLR, 1'b0, 1'b0, c0 + 1);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 2);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 3);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.op_valid = 1'b0;
`ifdef MAC_SEQ_STALL_TIMEOUT_EN
    push(CMD_NOP, 1'b1, 1'b1, c0 + 4 + TIMEOUT);
    repeat (TIMEOUT + 2) tick();
`else
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.busy || bus.err) bad++;
      tick();
    end
    chk(bad == 0, "stall_hold", $sformatf("%0d of 100 stall cycles had busy=0 or err=1, required 0", bad));
    c0 = cyc;
    bus.op_valid = 1'b1;
    push(CMD_MAC, 1'b0, 1'b0, c0);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 1);
    push(CMD_MAC, 1'b0, 1'b0, c0 + 2);
    push(CMD_RD,  1'b0, 1'b0, c0 + 3);
    push(CMD_NOP, 1'b1, 1'b0, c0 + 4);
    repeat (3) tick();
    bus.op_valid = 1'b0;
    repeat (2) tick();
`endif
    tick();

    chk(exp_q.size() == 0, "drain", $sformatf("%0d events still pending, required 0", exp_q.size()));
    chk(done_seen == done_exp, "done_count", $sformatf("got %0d DONE pulses, required %0d", done_seen, done_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mac_cmd_sequencer.md
Name: mac_cmd_sequencer

Overview:
Issues the 2-bit command stream that drives the MAC unit's control FSM; it is the command-issuing end of that control interface.
- Accepts a dot-product job (START + LEN) and emits CLR, then one MAC command per accepted operand pair, then RD.
- Throttles with a valid/ready handshake toward the operand source and reports BUSY/DONE upward.

Parameters:
LEN_W, 8, width of job length and element counter
TIMEOUT, 16, stall cycles before abort (used only with the optional feature)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  job request, sampled only in IDLE
LEN  input  LEN_W  number of operand pairs in job, sampled with START
OP_VALID  input  1  operand source has a pair on the MAC datapath inputs
OP_READY  output  1  sequencer consumes pair this cycle when OP_VALID=1
CMD  output  2  command to MAC control FSM: 00 NOP, 01 MAC, 10 CLR, 11 RD
BUSY  output  1  job in progress
DONE  output  1  one-cycle pulse, job finished, result valid at MAC output
ERR  output  1  stall abort flag (tied 0 when feature compiled out)

Behaviour:
- Interface decided: one clock CLK; reset RST is synchronous and active-high.
- Reset: state=IDLE, count=0, len_q=0. CMD=00, OP_READY=0, BUSY=0, DONE=0, ERR=0 from the first edge with RST=1.
- RST has priority over all inputs. Reset mid-job abandons the job with no DONE; CMD=NOP on the next cycle.
- States: IDLE, CLEAR, RUN, FLUSH, FIN. Moore outputs decode from the state register. The only Mealy term is CMD in RUN.
- IDLE: CMD=NOP, BUSY=0. START=1 at edge -> latch LEN into len_q, count=0, go to CLEAR.
- CLEAR: CMD=CLR for exactly one cycle, BUSY=1. Next state is RUN if len_q!=0, else FLUSH.
- RUN: OP_READY=1, BUSY=1, CMD = OP_VALID ? MAC : NOP.
  - A transfer is OP_VALID & OP_READY at an edge; count increments by 1.
  - When a transfer makes count==len_q, go to FLUSH at the same edge.
  - OP_VALID=0 holds state and count (stall).
- FLUSH: CMD=RD for exactly one cycle, OP_READY=0, BUSY=1. Next state is FIN.
- FIN: DONE=1, BUSY=1, CMD=NOP for one cycle. Next state is IDLE.
- Latency: START edge -> CLR in the next cycle.
  - Last transfer edge -> RD in the next cycle, DONE one cycle after RD.
  - Zero-stall job of N pairs: START to DONE = N+3 cycles.
- START outside IDLE is ignored; LEN is not re-sampled.
- Back-to-back jobs: START held high during FIN is ignored. It is accepted on the first IDLE cycle, giving a minimum 1-cycle IDLE gap.
- LEN=0: the sequence is CLR, RD, DONE with no MAC and OP_READY never high.
- LEN=2^LEN_W-1 (maximum): count reaches all-ones without wrap. count width is LEN_W and the compare is equality.
- Simultaneous RST and START: reset wins, and START is not latched.

Optional Feature:
Macro: MAC_SEQ_STALL_TIMEOUT_EN
- With macro defined:
  - A stall counter (ceil(log2(TIMEOUT+1)) bits) counts consecutive RUN cycles with OP_VALID=0 and clears on any transfer.
  - When it reaches TIMEOUT, go to FIN with CMD=NOP. There is no RD; DONE=1 and ERR=1 for that FIN cycle only.
  - The stall counter clears on reset and on leaving RUN.
- Without macro: no counter; ERR tied 0; RUN waits indefinitely.

Decomposition:
- Shared package/header mac_pkg: CMD encodings (CMD_NOP=2'b00, CMD_MAC=2'b01, CMD_CLR=2'b10, CMD_RD=2'b11) and state encodings (3-bit, IDLE=0, CLEAR=1, RUN=2, FLUSH=3, FIN=4). The MAC control FSM uses the same package.
- One sub-module, mac_seq_counter: LEN_W-bit element counter with sync clear, enable and terminal-compare output. The stall counter reuses it with a different width.

Test Plan:
- Reset: RST=1 for 2 cycles during RUN -> next cycle CMD=00, BUSY=0, OP_READY=0, no DONE.
- Zero-stall job: LEN=4, OP_VALID=1 always -> CMD sequence 10,01,01,01,01,11,00; DONE high 7 cycles after the START edge; exactly 4 transfers.
- Stalled job: LEN=3, OP_VALID pattern 1,0,0,1,1 -> CMD in RUN is 01,00,00,01,01; DONE 1 cycle after RD; count never exceeds 3.
- Edge jobs:
  - LEN=0 -> CMD 10,11 then DONE; OP_READY stays 0.
  - START pulsed during RUN -> ignored; DONE count=1.
  - LEN=255 with LEN_W=8 -> exactly 255 MAC commands.
- Back-to-back: START held high continuously with LEN=2 -> second CLR appears 1 IDLE cycle after the first DONE.
- MAC_SEQ_STALL_TIMEOUT_EN, TIMEOUT=16:
  - LEN=5, OP_VALID=0 after 2 transfers -> after 16 stall cycles, DONE=1 and ERR=1 with no RD.
  - Compiled out -> ERR stays 0 and BUSY stays 1 for 100 cycles.
